// File: rtl/barrel_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// The mode enum travels with each operand down the pipe.
package barrel_pkg;

   typedef enum logic [1:0] {
      ROR = 2'b00,
      ROL = 2'b01,
      LSR = 2'b10,
      ASR = 2'b11
   } mode_t;

   function automatic logic [63:0] bit_rev(input logic [63:0] v, input int w);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 64; i++) begin
         if (i < w) r[i] = v[6'(w - 1 - i)];
      end
      return r;
   endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// One combinational barrel stage: optional right shift by SHIFT.
// Vacated bits are filled by wrap, zero or sign depending on mode.
module barrel_shift_stage
   import barrel_pkg::*;
#(
   parameter int W     = 8,
   parameter int SHIFT = 1
) (
   input  logic [W-1:0] d,
   input  logic         en,
   input  logic [1:0]   fill_mode,
   input  logic         sign,
   output logic [W-1:0] q
);

   logic [SHIFT-1:0] w_fill;

   always_comb begin
      w_fill = '0;
      unique case (mode_t'(fill_mode))
         ROR, ROL: w_fill = d[SHIFT-1:0];
         ASR:      w_fill = {SHIFT{sign}};
         default:  w_fill = '0;
      endcase
   end

   assign q = en ? {w_fill, d[W-1:SHIFT]} : d;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined W-bit barrel shifter: ROR, ROL, LSR, ASR.
// ROL is computed as reverse -> ROR -> reverse around the stage chain.
module barrel_shifter_pipe
   import barrel_pkg::*;
#(
   parameter int W          = 8,
   parameter int REG_STRIDE = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [W-1:0]         in_data,
   input  logic [$clog2(W)-1:0] in_amt,
   input  logic [1:0]           in_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [W-1:0]         out_data
);

   localparam int N   = $clog2(W);
   localparam int LAT = (N + REG_STRIDE - 1) / REG_STRIDE;

   logic           w_adv;
   logic [W-1:0]   w_sd [N];
   logic [W-1:0]   w_sq [N];
   logic [N-1:0]   w_sa [N];
   logic [1:0]     w_sm [N];
   logic           w_ss [N];

   logic           r_valid [LAT];
   logic [W-1:0]   r_data  [LAT];
   logic [N-1:0]   r_amt   [LAT];
   logic [1:0]     r_mode  [LAT];
   logic           r_sign  [LAT];

   // Index of the stage whose output feeds register bank b.
   function automatic int last_stg(input int b);
      return ((b + 1) * REG_STRIDE > N) ? N - 1 : (b + 1) * REG_STRIDE - 1;
   endfunction

   assign w_adv    = !out_valid || out_ready;
   assign in_ready = w_adv;

   for (genvar k = 0; k < N; k++) begin : g_stg
      if (k == 0) begin : g_in
         assign w_sd[k] = (mode_t'(in_mode) == ROL)
                        ? W'(bit_rev(64'(in_data), W)) : in_data;
         assign w_sa[k] = in_amt;
         assign w_sm[k] = in_mode;
         assign w_ss[k] = in_data[W-1];
      end else if (k % REG_STRIDE == 0) begin : g_reg
         assign w_sd[k] = r_data[k/REG_STRIDE-1];
         assign w_sa[k] = r_amt[k/REG_STRIDE-1];
         assign w_sm[k] = r_mode[k/REG_STRIDE-1];
         assign w_ss[k] = r_sign[k/REG_STRIDE-1];
      end else begin : g_chain
         assign w_sd[k] = w_sq[k-1];
         assign w_sa[k] = w_sa[k-1];
         assign w_sm[k] = w_sm[k-1];
         assign w_ss[k] = w_ss[k-1];
      end

      barrel_shift_stage #(
         .W     (W),
         .SHIFT (1 << k)
      ) u_stage (
         .d         (w_sd[k]),
         .en        (w_sa[k][k]),
         .fill_mode (w_sm[k]),
         .sign      (w_ss[k]),
         .q         (w_sq[k])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int b = 0; b < LAT; b++) begin
            r_valid[b] <= 1'b0;
            r_data[b]  <= '0;
            r_amt[b]   <= '0;
            r_mode[b]  <= '0;
            r_sign[b]  <= 1'b0;
         end
      end else if (w_adv) begin
         r_valid[0] <= in_valid;
         for (int b = 1; b < LAT; b++) begin
            r_valid[b] <= r_valid[b-1];
         end
         for (int b = 0; b < LAT; b++) begin
            r_data[b] <= w_sq[last_stg(b)];
            r_amt[b]  <= w_sa[last_stg(b)];
            r_mode[b] <= w_sm[last_stg(b)];
            r_sign[b] <= w_ss[last_stg(b)];
         end
      end
   end

   assign out_valid = r_valid[LAT-1];
   assign out_data  = (mode_t'(r_mode[LAT-1]) == ROL)
                    ? W'(bit_rev(64'(r_data[LAT-1]), W)) : r_data[LAT-1];

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Bench for barrel_shifter_pipe: W=8/STRIDE=1 directed cases and
// a W=32/STRIDE=2 random stream, both scored through expected-value queues.
module tb_barrel_shifter_pipe;
   import barrel_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int errors = 0;

   logic       iv8, ir8, ov8, or8;
   logic [7:0] id8, od8;
   logic [2:0] ia8;
   logic [1:0] im8;

   logic        iv32, ir32, ov32, or32;
   logic [31:0] id32, od32;
   logic [4:0]  ia32;
   logic [1:0]  im32;

   logic [7:0]  q8[$];
   logic [31:0] q32[$];
   int          ocyc8[$];
   int          n_out8 = 0;
   int          n_out32 = 0;
   int          n_in32 = 0;

   barrel_shifter_pipe #(.W(8), .REG_STRIDE(1)) u_dut8 (
      .clk(clk), .reset(rst),
      .in_valid(iv8), .in_ready(ir8), .in_data(id8),
      .in_amt(ia8), .in_mode(im8),
      .out_valid(ov8), .out_ready(or8), .out_data(od8)
   );

   barrel_shifter_pipe #(.W(32), .REG_STRIDE(2)) u_dut32 (
      .clk(clk), .reset(rst),
      .in_valid(iv32), .in_ready(ir32), .in_data(id32),
      .in_amt(ia32), .in_mode(im32),
      .out_valid(ov32), .out_ready(or32), .out_data(od32)
   );

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at cycle %0d",
                  name, act, exp, cyc);
      end
   endtask

   // Rotate/shift on a w-bit value using plain wide arithmetic.
   function automatic logic [63:0] ref_model(input logic [63:0] d_in,
      input int a, input int m, input int w);
      logic [63:0]        mask, d, r;
      logic signed [63:0] s;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      d = d_in & mask;
      case (m)
         0: r = (d >> a) | (d << (w - a));
         1: r = (d << a) | (d >> (w - a));
         2: r = d >> a;
         default: begin
            s = $signed(d << (64 - w));
            s = s >>> (64 - w + a);
            r = 64'(s);
         end
      endcase
      return r & mask;
   endfunction

   always @(negedge clk) begin
      if (!rst && ov8 && or8) begin
         n_out8++;
         ocyc8.push_back(cyc);
         if (q8.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out8_unexpected got %0h expected none", od8);
         end else begin
            chk("out8", 64'(od8), 64'(q8.pop_front()));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("in_ready32", 64'(ir32), 64'(!ov32 || or32));
         if (ov32 && or32) begin
            n_out32++;
            if (q32.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL out32_unexpected got %0h expected none", od32);
            end else begin
               chk("out32", 64'(od32), 64'(q32.pop_front()));
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the transfer edge.
   task automatic send8(input logic [7:0] d, input logic [2:0] a,
                        input logic [1:0] m, input logic [7:0] exp);
      bit ok;
      ok  = 1'b0;
      iv8 = 1'b1;
      id8 = d;
      ia8 = a;
      im8 = m;
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         if (ir8) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      chk("send8_accept", 64'(ok), 64'd1);
      if (ok) q8.push_back(exp);
      @(posedge clk);
      #1;
      iv8 = 1'b0;
   endtask

   task automatic drain8();
      for (int t = 0; t < 60 && q8.size() != 0; t++) @(posedge clk);
      chk("drain8", 64'(q8.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] r8;
      logic [2:0] a8;
      logic [1:0] m8;
      logic [7:0] held;
      bit         seen;
      int         n;
      int         iter;

      rst = 1'b1;
      iv8 = 1'b0; id8 = '0; ia8 = '0; im8 = '0; or8 = 1'b1;
      iv32 = 1'b0; id32 = '0; ia32 = '0; im32 = '0; or32 = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ov8", 64'(ov8), 64'd0);
      chk("rst_od8", 64'(od8), 64'd0);
      chk("rst_ov32", 64'(ov32), 64'd0);
      chk("rst_od32", 64'(od32), 64'd0);
      chk("rst_ir8", 64'(ir8), 64'd1);
      @(posedge clk);
      #1;

      // Single ROR, latency check
      send8(8'h96, 3'd1, ROR, 8'h4B);
      n = 0;
      for (int t = 1; t <= 20; t++) begin
         @(negedge clk);
         if (ov8) begin
            n = t;
            break;
         end
      end
      chk("lat8", 64'(n), 64'd3);
      drain8();

      // Mixed modes back to back
      ocyc8.delete();
      send8(8'h81, 3'd3, ROL, 8'h0C);
      send8(8'hF0, 3'd4, LSR, 8'h0F);
      send8(8'h90, 3'd2, ASR, 8'hE4);
      drain8();
      chk("b2b_cnt", 64'(ocyc8.size()), 64'd3);
      if (ocyc8.size() == 3)
         chk("b2b_consec", 64'(ocyc8[2] - ocyc8[0]), 64'd2);

      // Backpressure: hold out_ready low for 4 cycles
      n_out8 = 0;
      seen   = 1'b0;
      fork
         begin
            for (int i = 0; i < 5; i++) begin
               r8 = 8'($urandom);
               a8 = 3'($urandom);
               m8 = 2'($urandom);
               send8(r8, a8, m8, 8'(ref_model(64'(r8), int'(a8), int'(m8), 8)));
            end
         end
         begin
            for (int t = 0; t < 40; t++) begin
               @(posedge clk);
               #1;
               if (ov8) begin
                  seen = 1'b1;
                  break;
               end
            end
            or8  = 1'b0;
            held = od8;
            repeat (4) begin
               @(negedge clk);
               chk("bp_in_ready", 64'(ir8), 64'd0);
               chk("bp_valid", 64'(ov8), 64'd1);
               chk("bp_hold", 64'(od8), 64'(held));
               @(posedge clk);
               #1;
            end
            or8 = 1'b1;
         end
      join
      chk("bp_seen", 64'(seen), 64'd1);
      drain8();
      chk("bp_count", 64'(n_out8), 64'd5);

      // Reset with two operands in flight
      n_out8 = 0;
      send8(8'h11, 3'd1, ROR, 8'h88);
      send8(8'h22, 3'd2, LSR, 8'h08);
      rst = 1'b1;
      q8.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_ov8", 64'(ov8), 64'd0);
      chk("rst_mid_od8", 64'(od8), 64'd0);
      repeat (8) @(posedge clk);
      chk("rst_mid_drop", 64'(n_out8), 64'd0);
      #1;

      // Boundaries
      for (int m = 0; m < 4; m++) begin
         r8 = 8'($urandom);
         send8(r8, 3'd0, 2'(m), r8);
      end
      send8(8'h80, 3'd7, ROR, 8'h01);
      send8(8'h80, 3'd7, LSR, 8'h01);
      send8(8'h80, 3'd7, ASR, 8'hFF);
      send8(8'h80, 3'd7, ROL, 8'h40);
      send8(8'h7F, 3'd7, ASR, 8'h00);
      drain8();

      // W=32 random stream with random backpressure
      iter = 0;
      while (n_in32 < 10000 && iter < 60000) begin
         iter++;
         iv32 = ($urandom_range(0, 3) != 0);
         id32 = $urandom;
         ia32 = 5'($urandom);
         im32 = 2'($urandom);
         or32 = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (iv32 && ir32) begin
            q32.push_back(32'(ref_model(64'(id32), int'(ia32), int'(im32), 32)));
            n_in32++;
         end
         @(posedge clk);
         #1;
      end
      chk("rand32_budget", 64'(n_in32), 64'd10000);
      iv32 = 1'b0;
      or32 = 1'b1;
      for (int t = 0; t < 60 && q32.size() != 0; t++) @(posedge clk);
      @(posedge clk);
      chk("drain32", 64'(q32.size()), 64'd0);
      chk("n_out32", 64'(n_out32), 64'(n_in32));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
